// File: rtl/freq_meas_ctrl_if.sv
// Result channel of the frequency-meter sequencer.
//
// Handshake: the master raises Valid together with a new Frequency/Overflow
// pair and holds all three until a cycle in which Valid & Ready are both high
// (a transfer). A newer result may replace an unaccepted one; the master then
// raises the sticky Missed flag. Ready may be driven freely by the slave and
// is not required to wait for Valid.
//
// Signals:
//   Frequency [CNT_W] : edge count of the last completed gate window
//   Overflow          : that count saturated
//   Valid             : result available
//   Ready             : consumer accepts the result when Valid is high
//   Missed            : sticky, an unaccepted result was overwritten
interface freq_meas_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [CNT_W-1:0] Frequency;
    logic             Overflow;
    logic             Valid;
    logic             Ready;
    logic             Missed;

    modport master (
        output Frequency,
        output Overflow,
        output Valid,
        output Missed,
        input  Ready
    );

    modport slave (
        input  Frequency,
        input  Overflow,
        input  Valid,
        input  Missed,
        output Ready
    );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the frequency-meter datapath.
// Counts rising edges of the asynchronous Fxin over a gate window of
// GATE_BASE, GATE_BASE/10 or GATE_BASE/100 Clk cycles, single-shot or
// continuously re-armed, and publishes each count with a saturation flag
// on the result channel (see freq_meas_ctrl_if for the handshake).
//
// Ports:
//   Clk        : system clock
//   Rst_n      : asynchronous active-low reset
//   Fxin       : asynchronous signal under measurement
//   Start      : one-cycle pulse, starts a measurement when idle
//   Continuous : re-arm a new window right after each result
//   Gate_sel   : 00/11 GATE_BASE, 01 GATE_BASE/10, 10 GATE_BASE/100
//   Gate       : high exactly while the gate window is open
//   Busy       : high whenever the sequencer is not idle
//   Dbg_state  : current sequencer state (0 idle, 1 gate, 2 latch)
//   res        : result channel (Frequency, Overflow, Valid, Ready, Missed)
module freq_meas_ctrl #(
    parameter int CNT_W     = 16,
    parameter int GATE_BASE = 100_000_000,
    parameter int SYNC_STG  = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Fxin,
    input  logic       Start,
    input  logic       Continuous,
    input  logic [1:0] Gate_sel,
    output logic       Gate,
    output logic       Busy,
    output logic [1:0] Dbg_state,
    freq_meas_ctrl_if.master res
);

    localparam int GW = $clog2(GATE_BASE + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GATE  = 2'd1,
        S_LATCH = 2'd2
    } state_e;

    state_e               state_q;
    logic [SYNC_STG-1:0]  sync_q;
    logic                 hist_q;
    logic                 rise;
    logic [GW-1:0]        gate_cnt_q;
    logic [GW-1:0]        gate_load_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sat_q;
    logic [CNT_W-1:0]     freq_q;
    logic                 ovf_q;
    logic                 valid_q;
    logic                 missed_q;
    logic                 gate_q;
    logic                 busy_q;

    // Fxin synchroniser plus one history flop; rise is a single-cycle pulse
    // per synchronised rising edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], Fxin};
            hist_q <= sync_q[SYNC_STG-1];
        end
    end

    assign rise = sync_q[SYNC_STG-1] & ~hist_q;

    // Window length minus one: the down-counter reaching zero marks the
    // last gated cycle, so the window spans exactly N cycles.
    always_comb begin
        gate_load_d = GW'(GATE_BASE - 1);
        unique case (Gate_sel)
            2'b01:   gate_load_d = GW'(GATE_BASE / 10 - 1);
            2'b10:   gate_load_d = GW'(GATE_BASE / 100 - 1);
            default: gate_load_d = GW'(GATE_BASE - 1);
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            gate_cnt_q <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            missed_q   <= 1'b0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // A transfer clears Valid; a LATCH in the same cycle overrides
            // this below so the new result stays visible.
            if (valid_q && res.Ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_q    <= S_GATE;
                        gate_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        gate_cnt_q <= gate_load_d;
                        cnt_q      <= '0;
                        sat_q      <= 1'b0;
                    end
                end

                S_GATE: begin
                    if (rise) begin
                        if (cnt_q == '1) begin
                            sat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    if (gate_cnt_q == '0) begin
                        state_q <= S_LATCH;
                        gate_q  <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q - GW'(1);
                    end
                end

                S_LATCH: begin
                    freq_q  <= cnt_q;
                    ovf_q   <= sat_q;
                    valid_q <= 1'b1;
                    if (valid_q && !res.Ready) begin
                        missed_q <= 1'b1;
                    end
                    if (Continuous) begin
                        // Re-arm: the single LATCH cycle is the only
                        // non-gated gap between back-to-back windows.
                        state_q    <= S_GATE;
                        gate_q     <= 1'b1;
                        gate_cnt_q <= gate_load_d;
                        cnt_q      <= '0;
                        sat_q      <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    gate_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Gate          = gate_q;
    assign Busy          = busy_q;
    assign Dbg_state     = state_q;
    assign res.Frequency = freq_q;
    assign res.Overflow  = ovf_q;
    assign res.Valid     = valid_q;
    assign res.Missed    = missed_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
module tb_freq_meas_ctrl;
    localparam int GATE_BASE = 1000;
    localparam int SYNC_STG  = 2;

    // ---------------- clock / reset / shared stimulus ----------------
    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Fxin = 1'b0;
    logic       Start;
    logic       Continuous;
    logic [1:0] Gate_sel;
    logic       ready;
    logic       gate16, busy16, gate4, busy4;
    logic [1:0] dbg16, dbg4;

    always #5 Clk = ~Clk;

    freq_meas_ctrl_if #(.CNT_W(16)) if16 ();
    freq_meas_ctrl_if #(.CNT_W(4))  if4 ();
    assign if16.Ready = ready;
    assign if4.Ready  = ready;

    freq_meas_ctrl #(.CNT_W(16), .GATE_BASE(GATE_BASE), .SYNC_STG(SYNC_STG)) dut16 (
        .Clk(Clk), .Rst_n(Rst_n), .Fxin(Fxin), .Start(Start), .Continuous(Continuous),
        .Gate_sel(Gate_sel), .Gate(gate16), .Busy(busy16), .Dbg_state(dbg16), .res(if16)
    );

    freq_meas_ctrl #(.CNT_W(4), .GATE_BASE(GATE_BASE), .SYNC_STG(SYNC_STG)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Fxin(Fxin), .Start(Start), .Continuous(Continuous),
        .Gate_sel(Gate_sel), .Gate(gate4), .Busy(busy4), .Dbg_state(dbg4), .res(if4)
    );

    // ---------------- Fxin generator ----------------
    // Square wave of fx_period cycles, low until fx_t0 + period/2.
    int nc = 0;
    int fx_period = 0;
    int fx_t0 = 0;

    always @(negedge Clk) begin
        nc = nc + 1;
        if (fx_period == 0 || nc < fx_t0) Fxin = 1'b0;
        else Fxin = (((nc - fx_t0) % fx_period) >= (fx_period / 2));
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Windows are tracked as intervals of edge indices: a window opened at
    // edge s with length n gates cycles s..s+n-1, the result appears at edge
    // s+n+1. Rises are Fxin 0->1 transitions seen through a SYNC_STG delay.
    int m_k, m_s, m_n, m_cnt;
    bit m_active, m_valid, m_missed, m_gate;
    int m_freq16, m_freq4;
    bit m_ovf16, m_ovf4;
    bit fh [0:SYNC_STG];
    bit was_active, pub, m_rise;

    function automatic int gate_n(input logic [1:0] sel);
        if (sel == 2'b01) return GATE_BASE / 10;
        if (sel == 2'b10) return GATE_BASE / 100;
        return GATE_BASE;
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_k = 0; m_s = 0; m_n = 0; m_cnt = 0;
            m_active = 0; m_valid = 0; m_missed = 0; m_gate = 0;
            m_freq16 = 0; m_freq4 = 0; m_ovf16 = 0; m_ovf4 = 0;
            for (int i = 0; i <= SYNC_STG; i++) fh[i] = 0;
        end else begin
            m_k = m_k + 1;
            for (int i = SYNC_STG; i > 0; i--) fh[i] = fh[i-1];
            fh[0] = Fxin;
            m_rise = fh[SYNC_STG-1] & ~fh[SYNC_STG];
            was_active = m_active;
            pub = m_active && (m_k == m_s + m_n + 1);
            if (pub) begin
                m_freq16 = (m_cnt > 65535) ? 65535 : m_cnt;
                m_ovf16  = (m_cnt > 65535);
                m_freq4  = (m_cnt > 15) ? 15 : m_cnt;
                m_ovf4   = (m_cnt > 15);
                if (m_valid && !ready) m_missed = 1;
                m_valid = 1;
                if (Continuous) begin
                    m_s = m_k; m_n = gate_n(Gate_sel); m_cnt = 0;
                end else begin
                    m_active = 0;
                end
            end else if (m_valid && ready) begin
                m_valid = 0;
            end
            if (!was_active && Start) begin
                m_active = 1; m_s = m_k; m_n = gate_n(Gate_sel); m_cnt = 0;
            end
            m_gate = m_active && (m_k >= m_s) && (m_k < m_s + m_n);
            if (m_gate && m_rise) m_cnt = m_cnt + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge Clk) begin
        #1;
        if (chk_en) begin
            chk("gate16",   32'(gate16),          32'(m_gate));
            chk("busy16",   32'(busy16),          32'(m_active));
            chk("valid16",  32'(if16.Valid),      32'(m_valid));
            chk("missed16", 32'(if16.Missed),     32'(m_missed));
            chk("freq16",   32'(if16.Frequency),  32'(m_freq16));
            chk("ovf16",    32'(if16.Overflow),   32'(m_ovf16));
            chk("gate4",    32'(gate4),           32'(m_gate));
            chk("busy4",    32'(busy4),           32'(m_active));
            chk("valid4",   32'(if4.Valid),       32'(m_valid));
            chk("missed4",  32'(if4.Missed),      32'(m_missed));
            chk("freq4",    32'(if4.Frequency),   32'(m_freq4));
            chk("ovf4",     32'(if4.Overflow),    32'(m_ovf4));
            chk("dbg16_nonidle", 32'(dbg16 != 2'd0), 32'(m_active));
            chk("dbg4_nonidle",  32'(dbg4 != 2'd0),  32'(m_active));
        end
    end

    // ---------------- driver tasks ----------------
    // Start must already be driven high at the current negedge. Returns the
    // number of negedges until Valid is seen and how many of them had Gate.
    task automatic measure(input bit disturb, output int lat, output int ghi);
        bit done;
        lat = 0; ghi = 0; done = 0;
        while (!done) begin
            @(negedge Clk);
            lat++;
            Start = (disturb && lat == 20);
            if (disturb && lat == 20) Gate_sel = 2'b00;
            if (disturb && lat == 40) Gate_sel = 2'b10;
            if (gate16) ghi++;
            if (if16.Valid === 1'b1 || lat >= 3000) done = 1;
        end
        chk("valid_seen", 32'(if16.Valid), 32'd1);
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge Clk);
        ready = 1'b0;
        @(negedge Clk);
        chk("accept_clears_valid", 32'(if16.Valid), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy16 !== 1'b0 && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        chk(name, 32'(busy16), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    int lat, ghi, f;

    initial begin
        Rst_n = 1'b0; Start = 1'b0; Continuous = 1'b0; Gate_sel = 2'b00; ready = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge Clk);
        chk("rst_valid",  32'(if16.Valid),     32'd0);
        chk("rst_freq",   32'(if16.Frequency), 32'd0);
        chk("rst_busy",   32'(busy16),         32'd0);
        chk("rst_missed", 32'(if16.Missed),    32'd0);

        // Reset in the middle of a window aborts it without a result.
        fx_period = 4; fx_t0 = nc;
        Gate_sel = 2'b00; Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        repeat (50) @(negedge Clk);
        chk("t1_gate_open", 32'(gate16), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("t1_rst_gate",  32'(gate16),         32'd0);
        chk("t1_rst_busy",  32'(busy16),         32'd0);
        chk("t1_rst_valid", 32'(if16.Valid),     32'd0);
        chk("t1_rst_freq",  32'(if16.Frequency), 32'd0);
        @(negedge Clk); Rst_n = 1'b1;
        repeat (1100) @(negedge Clk);
        chk("t1_no_valid", 32'(if16.Valid), 32'd0);

        // 1000-cycle window, Fxin period 40 starting 20 cycles after Start.
        fx_period = 0;
        repeat (5) @(negedge Clk);
        fx_t0 = nc; fx_period = 40;
        Gate_sel = 2'b00; Start = 1'b1;
        measure(1'b0, lat, ghi);
        chk("t2_latency",   32'(lat),             32'd1002);
        chk("t2_gate_len",  32'(ghi),             32'd1000);
        chk("t2_freq16",    32'(if16.Frequency),  32'd25);
        chk("t2_ovf16",     32'(if16.Overflow),   32'd0);
        chk("t2_freq4",     32'(if4.Frequency),   32'd15);
        chk("t2_ovf4",      32'(if4.Overflow),    32'd1);
        chk("t2_model",     32'(m_freq16),        32'd25);
        accept();

        // 10-cycle window, Fxin period 4, phase sweep.
        fx_period = 4;
        Gate_sel = 2'b10;
        for (int ph = 0; ph < 4; ph++) begin
            fx_t0 = nc + ph;
            repeat (2) @(negedge Clk);
            Start = 1'b1;
            measure(1'b0, lat, ghi);
            f = int'(if16.Frequency);
            chk("t3_latency",    32'(lat), 32'd12);
            chk("t3_gate_len",   32'(ghi), 32'd10);
            chk("t3_freq_range", 32'(f == 2 || f == 3), 32'd1);
            accept();
        end

        // 1000-cycle window, Fxin period 4: 250 edges, saturates 4-bit counter.
        Gate_sel = 2'b00; Start = 1'b1;
        measure(1'b0, lat, ghi);
        chk("t4_freq16", 32'(if16.Frequency), 32'd250);
        chk("t4_ovf16",  32'(if16.Overflow),  32'd0);
        chk("t4_freq4",  32'(if4.Frequency),  32'd15);
        chk("t4_ovf4",   32'(if4.Overflow),   32'd1);
        chk("t4_model",  32'(m_freq4),        32'd15);
        accept();

        // Continuous windows of 10 cycles: accept at LATCH, then overwrite.
        Gate_sel = 2'b10; Continuous = 1'b1; ready = 1'b0;
        Start = 1'b1;
        measure(1'b0, lat, ghi);
        chk("t5_latency", 32'(lat),          32'd12);
        chk("t5_missed0", 32'(if16.Missed),  32'd0);
        repeat (10) @(negedge Clk);
        ready = 1'b1;
        @(negedge Clk);
        ready = 1'b0;
        chk("t5_latch_accept_valid",  32'(if16.Valid),  32'd1);
        chk("t5_latch_accept_missed", 32'(if16.Missed), 32'd0);
        repeat (11) @(negedge Clk);
        f = int'(if16.Frequency);
        chk("t5_missed1",     32'(if16.Missed), 32'd1);
        chk("t5_valid_held",  32'(if16.Valid),  32'd1);
        chk("t5_freq_range",  32'(f == 2 || f == 3), 32'd1);
        Continuous = 1'b0; ready = 1'b1;
        @(negedge Clk);
        chk("t5_valid_drop", 32'(if16.Valid), 32'd0);
        wait_idle("t5_stops");
        @(negedge Clk);
        ready = 1'b0;
        chk("t5_final_valid", 32'(if16.Valid), 32'd0);

        // Start while busy and Gate_sel changes mid-window are ignored.
        Gate_sel = 2'b01; Start = 1'b1;
        measure(1'b1, lat, ghi);
        chk("t6_latency",  32'(lat), 32'd102);
        chk("t6_gate_len", 32'(ghi), 32'd100);
        chk("t6_missed_sticky", 32'(if16.Missed), 32'd1);
        accept();
        repeat (20) @(negedge Clk);
        chk("t6_no_restart", 32'(busy16), 32'd0);

        // Reset clears the sticky Missed flag.
        Rst_n = 1'b0;
        #1;
        chk("final_rst_missed", 32'(if16.Missed), 32'd0);
        @(negedge Clk); Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
